pc_sequencer: RTL and testbench

- Program-flow controller for the single-cycle core: owns the PC, resolves branches from the decoder's Branch/targetLUT outputs via a programmable 16-entry target LUT, and stalls fetch on multi-cycle data-memory accesses.
- Sits between the decoder (Branch, targetLUT, loadMem, storeMem), the ALU condition flag, instruction ROM (pc) and data memory (mem_req/mem_ready handshake).

---
 rtl/core_pkg.sv | 15 +
 rtl/branch_lut.sv | 26 ++
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared branch encodings, sequencer states and PC width
package core_pkg;
  localparam int PCW_DEF = 10;

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_JCND  = 2'b01;
  localparam logic [1:0] BR_NJCND = 2'b10;
  localparam logic [1:0] BR_JMP   = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, DONE} seq_state_t;

  function automatic logic br_taken(input logic [1:0] br, input logic cond);
    return (br == BR_JMP) || ((br == BR_JCND) && cond) || ((br == BR_NJCND) && !cond);
  endfunction
endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - branch-target register file, sync write, async read
module branch_lut #(
  parameter int PCW       = 10,
  parameter int LUT_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [3:0]     waddr,
  input  logic [PCW-1:0] wdata,
  input  logic [3:0]     raddr,
  output logic [PCW-1:0] rdata
);
  logic [PCW-1:0] mem [LUT_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A read racing a write to the same entry sees the old value.
  assign rdata = mem[raddr];
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC/branch/memory-stall sequencer; PC_SEQ_PERF_CNT_EN adds perf counters
module pc_sequencer
  import core_pkg::*;
#(
  parameter int PCW       = PCW_DEF,
  parameter int LUT_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [PCW-1:0] end_pc,
  input  logic [1:0]     Branch,
  input  logic [3:0]     targetLUT,
  input  logic           cond,
  input  logic           loadMem,
  input  logic           storeMem,
  input  logic           mem_ready,
  input  logic           lut_we,
  input  logic [3:0]     lut_addr,
  input  logic [PCW-1:0] lut_data,
  output logic [PCW-1:0] pc,
  output logic           run,
  output logic           mem_req,
  output logic           stall,
  output logic           done,
  output logic [31:0]    instr_count,
  output logic [31:0]    stall_count
);
  seq_state_t     state, state_next;
  logic [PCW-1:0] pc_next;
  logic [PCW-1:0] lut_target;
  logic           retire;

  branch_lut #(.PCW(PCW), .LUT_DEPTH(LUT_DEPTH)) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_we),
    .waddr (lut_addr),
    .wdata (lut_data),
    .raddr (targetLUT),
    .rdata (lut_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    mem_req    = 1'b0;
    stall      = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = '0;
        end
      end
      RUN: begin
        if (loadMem || storeMem) begin
          mem_req = 1'b1;
          if (mem_ready) retire = 1'b1;
          else begin
            stall      = 1'b1;
            state_next = MEM_WAIT;
          end
        end else begin
          retire = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = RUN;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A taken branch wins over end_pc so programs can loop through their last word.
    if (retire) begin
      if (br_taken(Branch, cond)) pc_next = lut_target;
      else if (pc == end_pc)      state_next = DONE;
      else                        pc_next = pc + 1'b1;
    end
  end

  assign run  = (state == RUN) || (state == MEM_WAIT);
  assign done = (state == DONE);

`ifdef PC_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      stall_count <= '0;
    end else if (start && (state == IDLE || state == DONE)) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (retire) instr_count <= instr_count + 32'd1;
      if (stall)  stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign instr_count = '0;
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  localparam int PCW = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [PCW-1:0] end_pc = '0;
  logic [1:0]     Branch = 2'b00;
  logic [3:0]     targetLUT = '0;
  logic           cond = 1'b0;
  logic           loadMem = 1'b0;
  logic           storeMem = 1'b0;
  logic           mem_ready = 1'b0;
  logic           lut_we = 1'b0;
  logic [3:0]     lut_addr = '0;
  logic [PCW-1:0] lut_data = '0;
  logic [PCW-1:0] pc;
  logic           run, mem_req, stall, done;
  logic [31:0]    instr_count, stall_count;

  int checks = 0;
  int failures = 0;

  pc_sequencer #(.PCW(PCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .end_pc(end_pc),
    .Branch(Branch), .targetLUT(targetLUT), .cond(cond),
    .loadMem(loadMem), .storeMem(storeMem), .mem_ready(mem_ready),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
    .pc(pc), .run(run), .mem_req(mem_req), .stall(stall), .done(done),
    .instr_count(instr_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if ({pc, run, mem_req, stall, done} !== {10'h000, 4'b0000}) begin
      failures++; $display("FAIL reset_outputs: got pc=%h run=%b req=%b stall=%b done=%b", pc, run, mem_req, stall, done);
    end
    checks++; if ({instr_count, stall_count} !== 64'd0) begin
      failures++; $display("FAIL reset_counters: got %0d %0d exp 0 0", instr_count, stall_count);
    end
    rst_n = 1'b1;
    step();
    checks++; if (run !== 1'b0 || pc !== 10'h000) begin
      failures++; $display("FAIL idle_no_start: got run=%b pc=%h exp run=0 pc=000", run, pc);
    end
  endtask

  task automatic test_sequential();
    end_pc = 10'd3;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc !== PCW'(i) || run !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL seq_pc%0d: got pc=%h run=%b done=%b exp pc=%h run=1 done=0", i, pc, run, done, i);
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (pc !== 10'd3 || done !== 1'b1 || run !== 1'b0) begin
        failures++; $display("FAIL seq_done%0d: got pc=%h done=%b run=%b exp pc=003 done=1 run=0", i, pc, done, run);
      end
      step();
    end
  endtask

  task automatic test_lut_write_in_done();
    logic [3:0]     addrs [3];
    logic [PCW-1:0] datas [3];
    addrs = '{4'd5, 4'd1, 4'd2};
    datas = '{10'h040, 10'h010, 10'h007};
    for (int i = 0; i < 3; i++) begin
      lut_we = 1'b1; lut_addr = addrs[i]; lut_data = datas[i];
      step();
    end
    lut_we = 1'b0;
    checks++; if (done !== 1'b1 || pc !== 10'd3) begin
      failures++; $display("FAIL lut_write_in_done: got done=%b pc=%h exp done=1 pc=003", done, pc);
    end
  endtask

  task automatic test_start_in_done();
    end_pc = 10'h3FF;
    pulse_start();
    checks++; if (pc !== 10'd0 || done !== 1'b0 || run !== 1'b1) begin
      failures++; $display("FAIL restart: got pc=%h done=%b run=%b exp pc=000 done=0 run=1", pc, done, run);
    end
  endtask

  task automatic test_branch();
    step(); step();
    Branch = 2'b11; targetLUT = 4'd5;
    lut_we = 1'b1; lut_addr = 4'd5; lut_data = 10'h080;
    step();
    lut_we = 1'b0;
    checks++; if (pc !== 10'h040) begin
      failures++; $display("FAIL jmp_old_value: got pc=%h exp 040", pc);
    end
    step();
    checks++; if (pc !== 10'h080) begin
      failures++; $display("FAIL jmp_new_value: got pc=%h exp 080", pc);
    end
    targetLUT = 4'd2;
    step();
    checks++; if (pc !== 10'h007) begin
      failures++; $display("FAIL jmp_lut2: got pc=%h exp 007", pc);
    end
    Branch = 2'b01; cond = 1'b0;
    step();
    checks++; if (pc !== 10'h008) begin
      failures++; $display("FAIL jcnd_not_taken: got pc=%h exp 008", pc);
    end
    Branch = 2'b10; cond = 1'b0; targetLUT = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (pc !== 10'h010 || run !== 1'b1) begin
      failures++; $display("FAIL njcnd_taken_start_ignored: got pc=%h run=%b exp pc=010 run=1", pc, run);
    end
    end_pc = 10'h010; Branch = 2'b01; cond = 1'b1; targetLUT = 4'd2;
    step();
    checks++; if (pc !== 10'h007 || run !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL branch_at_end_pc: got pc=%h run=%b done=%b exp pc=007 run=1 done=0", pc, run, done);
    end
    Branch = 2'b10; cond = 1'b1;
    step();
    checks++; if (pc !== 10'h008) begin
      failures++; $display("FAIL njcnd_not_taken: got pc=%h exp 008", pc);
    end
    Branch = 2'b00; cond = 1'b0; end_pc = 10'h3FF;
  endtask

  task automatic test_mem();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    end_pc = 10'd5;
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    checks++; if (pc !== 10'd4) begin
      failures++; $display("FAIL mem_reach_pc4: got pc=%h exp 004", pc);
    end
    loadMem = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (mem_req !== 1'b1 || stall !== 1'b1 || pc !== 10'd4) begin
        failures++; $display("FAIL load_wait%0d: got req=%b stall=%b pc=%h exp req=1 stall=1 pc=004", i, mem_req, stall, pc);
      end
      step();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || stall !== 1'b0) begin
      failures++; $display("FAIL load_ready: got req=%b stall=%b exp req=1 stall=0", mem_req, stall);
    end
    step();
    loadMem = 1'b0;
    checks++; if (pc !== 10'd5 || run !== 1'b1) begin
      failures++; $display("FAIL load_retire: got pc=%h run=%b exp pc=005 run=1", pc, run);
    end
    storeMem = 1'b1; mem_ready = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || stall !== 1'b0) begin
      failures++; $display("FAIL store_no_stall: got req=%b stall=%b exp req=1 stall=0", mem_req, stall);
    end
    step();
    storeMem = 1'b0; mem_ready = 1'b0;
    checks++; if (done !== 1'b1 || pc !== 10'd5) begin
      failures++; $display("FAIL mem_prog_done: got done=%b pc=%h exp done=1 pc=005", done, pc);
    end
`ifdef PC_SEQ_PERF_CNT_EN
    checks++; if (instr_count !== 32'd6 || stall_count !== 32'd3) begin
      failures++; $display("FAIL perf_counts: got instr=%0d stall=%0d exp 6 3", instr_count, stall_count);
    end
    pulse_start();
    checks++; if (instr_count !== 32'd0 || stall_count !== 32'd0) begin
      failures++; $display("FAIL perf_clear_on_start: got instr=%0d stall=%0d exp 0 0", instr_count, stall_count);
    end
`else
    checks++; if (instr_count !== 32'd0 || stall_count !== 32'd0) begin
      failures++; $display("FAIL perf_tied_off: got instr=%0d stall=%0d exp 0 0", instr_count, stall_count);
    end
    pulse_start();
`endif
  endtask

  task automatic test_reset_mid_wait();
    checks++; if (pc !== 10'd0 || run !== 1'b1) begin
      failures++; $display("FAIL rerun_start: got pc=%h run=%b exp pc=000 run=1", pc, run);
    end
    step(); step();
    loadMem = 1'b1; mem_ready = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1 || stall !== 1'b1 || pc !== 10'd2) begin
      failures++; $display("FAIL in_mem_wait: got req=%b stall=%b pc=%h exp req=1 stall=1 pc=002", mem_req, stall, pc);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || pc !== 10'd0 || run !== 1'b0) begin
      failures++; $display("FAIL async_reset_wait: got req=%b stall=%b pc=%h run=%b exp 0 0 000 0", mem_req, stall, pc, run);
    end
    loadMem = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (run !== 1'b0 || done !== 1'b0 || pc !== 10'd0) begin
      failures++; $display("FAIL idle_after_reset: got run=%b done=%b pc=%h exp 0 0 000", run, done, pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_lut_write_in_done();
    test_start_in_done();
    test_branch();
    test_mem();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
